// File: rtl/sync_fifo_param.sv
// Parametrised synchronous FIFO with registered flags, overflow/underflow pulses.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads (D_out shows the head word).
module sync_fifo_param #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned DEPTH     = 16,
   parameter int unsigned AF_THRESH = DEPTH - 2,
   parameter int unsigned AE_THRESH = 2
) (
   input  logic                       clock,
   input  logic                       rst,
   input  logic                       wr,
   input  logic                       rd,
   input  logic [WIDTH-1:0]           D_in,
   output logic [WIDTH-1:0]           D_out,
   output logic                       full,
   output logic                       empty,
   output logic                       almost_full,
   output logic                       almost_empty,
   output logic [$clog2(DEPTH):0]     fifo_cnt,
   output logic                       overflow,
   output logic                       underflow
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             wr_ok_c;
   logic             rd_ok_c;
   logic [CW-1:0]    cnt_nxt_c;

   // Acceptance qualifiers and next occupancy; flags are derived from the next count.
   always_comb begin
      wr_ok_c   = wr && !full;
      rd_ok_c   = rd && !empty;
      cnt_nxt_c = fifo_cnt;
      if (wr_ok_c && !rd_ok_c)
         cnt_nxt_c = fifo_cnt + CW'(1);
      else if (!wr_ok_c && rd_ok_c)
         cnt_nxt_c = fifo_cnt - CW'(1);
   end

   // Storage array is intentionally left unreset.
   always_ff @(posedge clock) begin
      if (!rst && wr_ok_c)
         mem[wr_ptr] <= D_in;
   end

   always_ff @(posedge clock) begin
      if (rst) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         fifo_cnt     <= '0;
         full         <= 1'b0;
         empty        <= 1'b1;
         almost_full  <= 1'b0;
         almost_empty <= 1'b1;
         overflow     <= 1'b0;
         underflow    <= 1'b0;
      end else begin
         if (wr_ok_c)
            wr_ptr <= wr_ptr + AW'(1);
         if (rd_ok_c)
            rd_ptr <= rd_ptr + AW'(1);
         fifo_cnt     <= cnt_nxt_c;
         full         <= (cnt_nxt_c == CW'(DEPTH));
         empty        <= (cnt_nxt_c == CW'(0));
         almost_full  <= (cnt_nxt_c >= CW'(AF_THRESH));
         almost_empty <= (cnt_nxt_c <= CW'(AE_THRESH));
         overflow     <= wr && full;
         underflow    <= rd && empty;
      end
   end

`ifdef SYNC_FIFO_FWFT_EN
   // Head word is presented directly; rd acknowledges it.
   assign D_out = mem[rd_ptr];
`else
   always_ff @(posedge clock) begin
      if (rst)
         D_out <= '0;
      else if (rd_ok_c)
         D_out <= mem[rd_ptr];
   end
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param: directed test-plan steps plus random traffic
// checked against a queue-based reference model.
module tb_sync_fifo_param;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned DEPTH = 16;

   logic             clock;
   logic             rst;
   logic             wr;
   logic             rd;
   logic [WIDTH-1:0] D_in;
   logic [WIDTH-1:0] D_out;
   logic             full;
   logic             empty;
   logic             almost_full;
   logic             almost_empty;
   logic [4:0]       fifo_cnt;
   logic             overflow;
   logic             underflow;

   sync_fifo_param #(
      .WIDTH(WIDTH), .DEPTH(DEPTH), .AF_THRESH(DEPTH - 2), .AE_THRESH(2)
   ) dut (
      .clock(clock), .rst(rst), .wr(wr), .rd(rd), .D_in(D_in), .D_out(D_out),
      .full(full), .empty(empty), .almost_full(almost_full),
      .almost_empty(almost_empty), .fifo_cnt(fifo_cnt),
      .overflow(overflow), .underflow(underflow)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   // Reference model: a queue of stored words plus the expected registered outputs.
   logic [WIDTH-1:0] q[$];
   logic [WIDTH-1:0] m_dout = '0;
   logic             m_ovf  = 1'b0;
   logic             m_unf  = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s @cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
   endtask

   task automatic step(input logic w, input logic r, input logic [WIDTH-1:0] d, input logic rs);
      int sz;
      wr = w; rd = r; D_in = d; rst = rs;
      @(posedge clock);
      cyc++;
      sz = q.size();
      if (rs) begin
         q.delete();
         m_dout = '0;
         m_ovf  = 1'b0;
         m_unf  = 1'b0;
      end else begin
         m_ovf = w && (sz == DEPTH);
         m_unf = r && (sz == 0);
         if (r && sz > 0) m_dout = q.pop_front();
         if (w && sz < DEPTH) q.push_back(d);
      end
      #1;
      sz = q.size();
      check("fifo_cnt",     32'(fifo_cnt),     32'(sz));
      check("full",         32'(full),         32'(sz == DEPTH));
      check("empty",        32'(empty),        32'(sz == 0));
      check("almost_full",  32'(almost_full),  32'(sz >= DEPTH - 2));
      check("almost_empty", 32'(almost_empty), 32'(sz <= 2));
      check("overflow",     32'(overflow),     32'(m_ovf));
      check("underflow",    32'(underflow),    32'(m_unf));
`ifdef SYNC_FIFO_FWFT_EN
      if (sz > 0) check("D_out_fwft", 32'(D_out), 32'(q[0]));
`else
      check("D_out", 32'(D_out), 32'(m_dout));
`endif
   endtask

   initial begin
      int wp;
      int rcount;
      logic w;
      logic r;
      wr = 1'b0; rd = 1'b0; D_in = '0; rst = 1'b1;

      // Reset state
      step(1'b0, 1'b0, 8'h00, 1'b1);
      step(1'b1, 1'b1, 8'h11, 1'b1);

      // Fill 0x00..0x0F, then a rejected 0xAA, then drain
      for (int i = 0; i < 16; i++) step(1'b1, 1'b0, WIDTH'(i), 1'b0);
      step(1'b1, 1'b0, 8'hAA, 1'b0);
      step(1'b0, 1'b0, 8'h00, 1'b0);
      for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'h00, 1'b0);
      step(1'b0, 1'b0, 8'h00, 1'b0);

      // Underflow for 3 cycles, then idle
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'h00, 1'b0);
      step(1'b0, 1'b0, 8'h00, 1'b0);

      // Simultaneous wr/rd on empty, then at count 5
      step(1'b1, 1'b1, 8'h40, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, WIDTH'(8'h41 + i), 1'b0);
      for (int i = 0; i < 4; i++) step(1'b1, 1'b1, WIDTH'(8'h50 + i), 1'b0);

      // Fill to full, then wr/rd together
      while (q.size() < DEPTH) step(1'b1, 1'b0, WIDTH'($urandom), 1'b0);
      step(1'b1, 1'b1, 8'hEE, 1'b0);
      step(1'b0, 1'b0, 8'h00, 1'b0);
      while (q.size() > 0) step(1'b0, 1'b1, 8'h00, 1'b0);

      // Wrap-around: 40 incrementing words, occupancy kept in 3..9 once primed
      wp = 0; rcount = 0;
      while (rcount < 40) begin
         w = (wp < 40) && (q.size() < 9) && ($urandom_range(0, 3) != 0);
         r = ((q.size() > 3) || (wp == 40 && q.size() > 0)) && ($urandom_range(0, 3) != 0);
         if (r) rcount++;
         step(w, r, WIDTH'(8'h80 + wp), 1'b0);
         if (w) wp++;
      end

      // Reset mid-operation at count 7 with wr high
      for (int i = 0; i < 7; i++) step(1'b1, 1'b0, WIDTH'(8'h70 + i), 1'b0);
      step(1'b1, 1'b0, 8'h77, 1'b1);
      step(1'b1, 1'b0, 8'h5C, 1'b0);
      step(1'b0, 1'b1, 8'h00, 1'b0);
      step(1'b0, 1'b0, 8'h00, 1'b0);

      // Head word visibility without rd, then pop
      step(1'b1, 1'b0, 8'h3E, 1'b0);
      step(1'b0, 1'b0, 8'h00, 1'b0);
      step(1'b0, 1'b1, 8'h00, 1'b0);

      // Random traffic with occasional reset
      for (int i = 0; i < 400; i++)
         step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), WIDTH'($urandom),
              ($urandom_range(0, 49) == 0));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parametrised synchronous FIFO that succeeds the fixed 8-bit × 16-entry write FIFO. Data width, depth and almost-full/almost-empty thresholds are configurable. The block adds registered almost-full/almost-empty flags, single-cycle overflow/underflow error pulses, and an optional first-word-fall-through read mode. It sits between the AXI write-channel BFM front end and the downstream consumer, and is driven and monitored through the existing `fifo_if`-style clocking blocks.

## Interface

Parameters:
- `WIDTH`, default 8: data word width in bits; must be ≥1.
- `DEPTH`, default 16: number of entries; power of two, ≥4.
- `AF_THRESH`, default `DEPTH-2`: `almost_full` asserts when count ≥ `AF_THRESH`; range 1..`DEPTH`.
- `AE_THRESH`, default 2: `almost_empty` asserts when count ≤ `AE_THRESH`; range 0..`DEPTH-1`.

Ports:
- `clock`, input, 1: the single clock; all logic is on posedge.
- `rst`, input, 1: synchronous, active-high reset.
- `wr`, input, 1: write request.
- `rd`, input, 1: read request.
- `D_in`, input, `WIDTH`: write data.
- `D_out`, output, `WIDTH`: read data.
- `full`, output, 1: count == `DEPTH`.
- `empty`, output, 1: count == 0.
- `almost_full`, output, 1: count ≥ `AF_THRESH`.
- `almost_empty`, output, 1: count ≤ `AE_THRESH`.
- `fifo_cnt`, output, `$clog2(DEPTH)+1`: current occupancy, 0..`DEPTH`.
- `overflow`, output, 1: one-cycle pulse when a write is rejected.
- `underflow`, output, 1: one-cycle pulse when a read is rejected.

## Operation

- **Storage:** `DEPTH × WIDTH` register array. `wr_ptr` and `rd_ptr` are `$clog2(DEPTH)` bits wide and wrap naturally from `DEPTH-1` to 0.
- **Write acceptance:** accepted iff `wr && !full`. An accepted write stores `D_in` at `mem[wr_ptr]` and increments `wr_ptr`.
- **Read acceptance:** accepted iff `rd && !empty`. An accepted read increments `rd_ptr`.
- **Count update:**
  - write only: +1.
  - read only: −1.
  - both accepted: unchanged.
  - neither accepted: unchanged.
- **Rejected write** (`wr && full`): memory, `wr_ptr` and count are untouched. `overflow` = 1 for the next cycle.
- **Rejected read** (`rd && empty`): pointers and `D_out` are untouched. `underflow` = 1 for the next cycle.
- **Simultaneous `wr && rd`:**
  - When full, the read is accepted and the write is rejected; `overflow` pulses and the count drops to `DEPTH-1`.
  - When empty, the write is accepted and the read is rejected; `underflow` pulses and the count rises to 1.
- **Flags:** `full`, `empty`, `almost_full`, `almost_empty` and `fifo_cnt` are all registered. They are computed from the next count, so they are consistent with `fifo_cnt` in the same cycle.
- **Reset:** `rst` = 1 at a posedge sets the following, regardless of `wr`/`rd`, and discards any in-flight data:
  - pointers = 0, `fifo_cnt` = 0;
  - `empty` = 1, `almost_empty` = 1;
  - `full` = 0, `almost_full` = 0;
  - `overflow` = 0, `underflow` = 0, `D_out` = 0.
- Memory contents are not reset.

## Timing

- **Write to flags:** an accepted write at edge N is reflected in `fifo_cnt` and all flags after edge N.
- **Standard read mode:** `D_out` is registered. After an accepted read at edge N, `D_out` = `mem[rd_ptr]` after edge N (one-cycle read latency). `D_out` holds its value when no read is accepted.
- **Write-to-read latency:** minimum 1 cycle. After a write at edge N, `empty` = 0 after N, so a read can be accepted at edge N+1.
- **Error pulses:** `overflow`/`underflow` last exactly one cycle per rejected request. Back-to-back rejections hold them high on consecutive cycles.
- **Drive timing:** inputs are sampled at posedge only. The bench drives with the #1 output skew of the clocking block.

## Configuration

- **Macro:** `SYNC_FIFO_FWFT_EN`.
- **Undefined (default):** standard registered-read mode as described above.
- **Defined (first-word-fall-through):**
  - `D_out` = `mem[rd_ptr]` combinationally; it is valid whenever `empty` = 0.
  - `rd` acknowledges (pops) the presented word, so the next word appears after the accepting edge.
  - The first written word is visible on `D_out` the cycle after the write edge, together with `empty` falling.
  - The reset value of `D_out` is don't-care while `empty` = 1; the bench checks `D_out` only when `empty` = 0.
  - All flag, count and error behaviour is identical to standard mode.

## Test plan

- **Fill and overflow** (WIDTH=8, DEPTH=16): write 0x00..0x0F.
  - `almost_full` rises at count 14; `full` and `fifo_cnt`=16 after the 16th write.
  - A 17th write of 0xAA gives a single `overflow` pulse; count stays 16.
  - Draining returns 0x00..0x0F in order, with no 0xAA.
- **Underflow:** `rd` asserted on an empty FIFO for 3 cycles.
  - `underflow` is high for 3 cycles; `fifo_cnt`=0 and `D_out` unchanged.
- **Simultaneous read/write at count 5:** 4 cycles of `wr`=`rd`=1.
  - Count stays 5; output order is preserved.
  - At full, `wr`=`rd`=1 gives count 15 and an `overflow` pulse.
- **Wrap-around:** 40 interleaved writes/reads of an incrementing pattern, keeping occupancy between 3 and 9.
  - All 40 words are read back in order; pointers wrap twice.
  - `almost_empty` toggles exactly at count 2/3.
- **Reset mid-operation:** at count 7, `rst` high for 1 cycle with `wr`=1.
  - Next cycle: `fifo_cnt`=0, `empty`=1, `D_out`=0.
  - A subsequent write of 0x5C is the first word read back.
- **FWFT** (with `SYNC_FIFO_FWFT_EN`): write 0x3E at edge N.
  - `D_out`=0x3E and `empty`=0 after N, with no `rd`.
  - `rd` at edge N+2 gives `empty`=1 after N+2.
